program_runner: RTL and testbench
=================================

PROGRAM_RUNNER -- requirements
Module: program_runner

Interface
REQ-001 The block SHALL take parameter MemoryElementWidth, default 12, as the width of operands, output data and output memory elements.
REQ-002 The block SHALL take parameter NProg, default 16, as the program memory depth; it is a power of two, >=2.
REQ-003 The block SHALL take parameter NOut, default 4, as the output ring depth; it is >=1.
REQ-004 The block SHALL take parameter MaxSteps, default 64, as the step limit before timeout.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port run, input, 1 bit: a one-cycle start pulse.
REQ-008 The block SHALL have port load_valid, input, 1 bit: a program write strobe.
REQ-009 The block SHALL have port load_addr, input, $clog2(NProg) bits: the program write address.
REQ-010 The block SHALL have port load_data, input, 2+MemoryElementWidth bits: {opcode[1:0], operand}.
REQ-011 The block SHALL have port expect0, input, MemoryElementWidth bits: the expected value of outMem[0].
REQ-012 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-014 The block SHALL have port out_data, output, MemoryElementWidth bits: the emitted value.
REQ-015 The block SHALL have port steps, output, 32 bits: the count of executed instructions.
REQ-016 The block SHALL have port finished, output, 1 bit: the program has ended (normally or by timeout).
REQ-017 The block SHALL have port success, output, 1 bit: the program ended normally and outMem[0]==expect0.
REQ-018 The block SHALL have port timeout, output, 1 bit: the program ended by reaching MaxSteps.

Function
REQ-019 The block SHALL decode opcodes as: 0 label (ip+1); 1 jmp (ip=operand mod NProg); 2 out (emit operand, ip+1); 3 halt.
REQ-020 The block SHALL implement states IDLE, RUN, STALL and DONE.
REQ-021 In IDLE, the block SHALL write load_data to prog[load_addr] on load_valid; run moves it to RUN with ip=0, steps=0, outMemPos=0 and outMem cleared.
REQ-022 The block SHALL ignore load_valid outside IDLE.
REQ-023 If load_valid and run are both high in IDLE, the write SHALL take effect and run SHALL start next cycle, so the program sees the new word.
REQ-024 In RUN, the block SHALL execute one instruction per clock and increment steps by 1 per executed instruction.
REQ-025 An out instruction SHALL assert out_valid with out_data=operand, write outMem[outMemPos]=operand, and advance outMemPos=(outMemPos+1) mod NOut, with wrap overwriting the oldest entry.
REQ-026 If out_ready is high in the same cycle as an out instruction, the out SHALL complete in that cycle; otherwise the block SHALL go to STALL.
REQ-027 In STALL, the block SHALL hold out_valid, out_data and ip stable, not increment steps, and return to RUN at ip+1 on the first cycle out_ready is high.
REQ-028 The ring write SHALL occur exactly once per out instruction, at acceptance.
REQ-029 out_valid SHALL be high only in the acceptance cycle of an out instruction and during STALL.
REQ-030 Normal end SHALL be either a halt, or ip incrementing past NProg-1 (wrap on increment is not allowed). Either SHALL move to DONE with finished=1, timeout=0, success=(outMem[0]==expect0).
REQ-031 When steps reaches MaxSteps before a normal end, the block SHALL move to DONE with finished=1, timeout=1, success=0. If the MaxSteps-th instruction is itself halt, the result SHALL be a normal end.
REQ-032 A jmp to itself SHALL loop until timeout.
REQ-033 In DONE, the block SHALL hold all outputs until reset or run; run SHALL restart as in REQ-021 and clear finished, success and timeout.
REQ-034 A run pulse while in RUN or STALL SHALL be ignored.
REQ-035 Program memory contents SHALL persist across run restarts.

Reset
REQ-036 On reset, the block SHALL enter IDLE with ip=0, steps=0, outMemPos=0, outMem all 0, out_valid=0, out_data=0, finished=0, success=0 and timeout=0.
REQ-037 On reset, prog contents SHALL be don't-care.
REQ-038 Reset mid-run, including in STALL, SHALL abort the run within one cycle with no further out_valid.

Verification
REQ-039 The bench SHALL cover: program {jmp 3, out 1, jmp 5, label, out 2, label}, expect0=2, out_ready=1, NProg=6-padded with halt -> single output 2, finished=1, success=1, timeout=0.
REQ-040 The bench SHALL cover: the same program with expect0=1 -> finished=1, success=0, timeout=0.
REQ-041 The bench SHALL cover: program {out 7, halt} with out_ready held low for 5 cycles -> out_valid=1 and out_data=7 stable for 6 cycles, steps unchanged while stalled, then finished=1 and steps=2.
REQ-042 The bench SHALL cover: NOut=2, program {out 1, out 2, out 3, halt}, expect0=3 -> outMem={3,2}, success=1 (ring wrap).
REQ-043 The bench SHALL cover: program {jmp 0}, MaxSteps=10 -> finished=1, timeout=1, success=0, steps=10.
REQ-044 The bench SHALL cover: reset asserted during STALL -> next cycle out_valid=0, finished=0 and state IDLE; a subsequent run re-executes correctly.

Source files
------------

// File: rtl/program_runner.sv
// Tiny program sequencer: loads a program, runs it one instruction per clock,
// emits out operands over a valid/ready port and records them in a small ring.
module program_runner #(
    parameter int MemoryElementWidth = 12,
    parameter int NProg              = 16,
    parameter int NOut               = 4,
    parameter int MaxSteps           = 64
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            run,
    input  logic                            load_valid,
    input  logic [$clog2(NProg)-1:0]        load_addr,
    input  logic [MemoryElementWidth+1:0]   load_data,
    input  logic [MemoryElementWidth-1:0]   expect0,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [MemoryElementWidth-1:0]   out_data,
    output logic [31:0]                     steps,
    output logic                            finished,
    output logic                            success,
    output logic                            timeout
);
    localparam int W  = MemoryElementWidth;
    localparam int AW = $clog2(NProg);
    localparam int PW = (NOut > 1) ? $clog2(NOut) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] STALL = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] OP_LABEL = 2'd0;
    localparam logic [1:0] OP_JMP   = 2'd1;
    localparam logic [1:0] OP_OUT   = 2'd2;
    localparam logic [1:0] OP_HALT  = 2'd3;

    logic [1:0]    state;
    logic [AW-1:0] ip;
    logic [PW-1:0] pos;
    logic [W+1:0]  prog    [NProg];
    logic [W-1:0]  out_mem [NOut];

    logic [1:0]    opcode;
    logic [W-1:0]  operand;
    logic          accept;
    logic          normal_end;
    logic          hit_limit;
    logic [31:0]   steps_exec;
    logic [W-1:0]  mem0_next;
    logic [PW-1:0] pos_next;

    always_comb begin
        opcode     = prog[ip][W+1:W];
        operand    = prog[ip][W-1:0];
        // ip and prog are frozen during STALL, so the stalled word is still prog[ip].
        out_valid  = (state == RUN && opcode == OP_OUT) || state == STALL;
        out_data   = out_valid ? operand : '0;
        accept     = out_valid && out_ready;
        normal_end = (opcode == OP_HALT) ||
                     (opcode != OP_JMP && ip == AW'(NProg - 1));
        steps_exec = (state == RUN) ? steps + 32'd1 : steps;
        hit_limit  = (steps_exec == 32'(MaxSteps));
        mem0_next  = (accept && pos == '0) ? operand : out_mem[0];
        pos_next   = (pos == PW'(NOut - 1)) ? '0 : pos + PW'(1);
    end

    // NOTE: program memory is deliberately kept out of the reset branch; its
    // contents are don't-care after reset, and resetting it would prevent RAM inference.
    always_ff @(posedge clock) begin
        if (!reset && state == IDLE && load_valid)
            prog[load_addr] <= load_data;
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the same pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            ip       <= '0;
            pos      <= '0;
            steps    <= '0;
            finished <= 1'b0;
            success  <= 1'b0;
            timeout  <= 1'b0;
            for (int i = 0; i < NOut; i++) out_mem[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (run) begin
                        state    <= RUN;
                        ip       <= '0;
                        pos      <= '0;
                        steps    <= '0;
                        finished <= 1'b0;
                        success  <= 1'b0;
                        timeout  <= 1'b0;
                        for (int i = 0; i < NOut; i++) out_mem[i] <= '0;
                    end
                end
                default: begin
                    steps <= steps_exec;
                    if (accept) begin
                        out_mem[pos] <= operand;
                        pos          <= pos_next;
                    end
                    if (out_valid && !out_ready) begin
                        state <= STALL;
                    end else if (normal_end) begin
                        state    <= DONE;
                        finished <= 1'b1;
                        success  <= (mem0_next == expect0);
                    end else if (hit_limit) begin
                        state    <= DONE;
                        finished <= 1'b1;
                        timeout  <= 1'b1;
                    end else begin
                        state <= RUN;
                        ip    <= (opcode == OP_JMP) ? operand[AW-1:0] : ip + AW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_program_runner.sv
// Directed bench for program_runner: normal runs, stall handling, ring wrap,
// timeout, restart from DONE and reset during STALL.
module tb_program_runner;
    logic        clock = 1'b0;
    logic        reset, run, load_valid, out_ready, out_valid;
    logic [3:0]  load_addr;
    logic [13:0] load_data;
    logic [11:0] expect0, out_data;
    logic [31:0] steps;
    logic        finished, success, timeout;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [13:0] img [16];
    int          n_out;
    logic [11:0] last_out;

    program_runner #(
        .MemoryElementWidth(12), .NProg(16), .NOut(2), .MaxSteps(10)
    ) dut (
        .clock(clock), .reset(reset), .run(run), .load_valid(load_valid),
        .load_addr(load_addr), .load_data(load_data), .expect0(expect0),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .steps(steps), .finished(finished), .success(success), .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] w(input logic [1:0] op, input logic [11:0] opnd);
        return {op, opnd};
    endfunction

    task automatic clear_img();
        for (int i = 0; i < 16; i++) img[i] = w(2'd3, 12'd0);
    endtask

    // Reset, load words 15..1, then write word 0 in the same cycle as run.
    task automatic load_and_run();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 15; a >= 1; a--) begin
            load_valid = 1'b1;
            load_addr  = 4'(a);
            load_data  = img[a];
            tick();
        end
        load_addr = 4'd0;
        load_data = img[0];
        run       = 1'b1;
        tick();
        load_valid = 1'b0;
        run        = 1'b0;
    endtask

    task automatic run_pulse();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        n_out    = 0;
        last_out = '0;
        for (int c = 0; c < budget && !finished; c++) begin
            if (out_valid && out_ready) begin
                n_out++;
                last_out = out_data;
            end
            tick();
        end
        check("done_within_budget", finished, 1);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; load_valid = 1'b0; load_addr = '0;
        load_data = '0; expect0 = '0; out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_state", dut.state, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_steps", steps, 0);
        check("rst_finished", finished, 0);
        check("rst_success", success, 0);
        check("rst_timeout", timeout, 0);
        check("rst_outmem0", dut.out_mem[0], 0);

        // jmp 3, out 1, jmp 5, label, out 2, label, halt...
        clear_img();
        img[0] = w(2'd1, 12'd3); img[1] = w(2'd2, 12'd1); img[2] = w(2'd1, 12'd5);
        img[3] = w(2'd0, 12'd0); img[4] = w(2'd2, 12'd2); img[5] = w(2'd0, 12'd0);
        expect0 = 12'd2; out_ready = 1'b1;
        load_and_run();
        wait_done(50);
        check("p1_n_out", n_out, 1);
        check("p1_out_data", last_out, 2);
        check("p1_finished", finished, 1);
        check("p1_success", success, 1);
        check("p1_timeout", timeout, 0);
        check("p1_steps", steps, 5);
        tick(); tick(); tick();
        check("p1_hold_finished", finished, 1);
        check("p1_hold_steps", steps, 5);
        check("p1_hold_success", success, 1);

        // Restart from DONE with the persisted program and a different expectation.
        expect0 = 12'd1;
        run_pulse();
        check("p2_restart_clears_finished", finished, 0);
        wait_done(50);
        check("p2_n_out", n_out, 1);
        check("p2_finished", finished, 1);
        check("p2_success", success, 0);
        check("p2_timeout", timeout, 0);

        // out 7, halt with the consumer stalling for five cycles.
        clear_img();
        img[0] = w(2'd2, 12'd7);
        expect0 = 12'd7; out_ready = 1'b0;
        load_and_run();
        check("p3_valid_c1", out_valid, 1);
        check("p3_data_c1", out_data, 7);
        check("p3_steps_c1", steps, 0);
        for (int i = 2; i <= 5; i++) begin
            tick();
            check("p3_stall_valid", out_valid, 1);
            check("p3_stall_data", out_data, 7);
            check("p3_stall_steps", steps, 1);
        end
        out_ready = 1'b1;
        check("p3_valid_c6", out_valid, 1);
        check("p3_data_c6", out_data, 7);
        wait_done(20);
        check("p3_n_out", n_out, 1);
        check("p3_finished", finished, 1);
        check("p3_steps", steps, 2);
        check("p3_success", success, 1);

        // Ring wrap with two entries: out 1, out 2, out 3, halt.
        clear_img();
        img[0] = w(2'd2, 12'd1); img[1] = w(2'd2, 12'd2); img[2] = w(2'd2, 12'd3);
        expect0 = 12'd3; out_ready = 1'b1;
        load_and_run();
        wait_done(30);
        check("p4_n_out", n_out, 3);
        check("p4_last_out", last_out, 3);
        check("p4_outmem0", dut.out_mem[0], 3);
        check("p4_outmem1", dut.out_mem[1], 2);
        check("p4_success", success, 1);
        check("p4_steps", steps, 4);

        // Self jump runs into the step limit.
        clear_img();
        img[0] = w(2'd1, 12'd0);
        expect0 = 12'd0;
        load_and_run();
        wait_done(50);
        check("p5_finished", finished, 1);
        check("p5_timeout", timeout, 1);
        check("p5_success", success, 0);
        check("p5_steps", steps, 10);

        // Reset while stalled, then a clean rerun of the same program.
        clear_img();
        img[0] = w(2'd2, 12'd7);
        expect0 = 12'd7; out_ready = 1'b0;
        load_and_run();
        tick();
        tick();
        check("p6_in_stall", dut.state, 2);
        check("p6_stall_valid", out_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("p6_rst_valid", out_valid, 0);
        check("p6_rst_finished", finished, 0);
        check("p6_rst_state", dut.state, 0);
        tick();
        check("p6_idle_valid", out_valid, 0);
        out_ready = 1'b1;
        run_pulse();
        wait_done(20);
        check("p6_n_out", n_out, 1);
        check("p6_last_out", last_out, 7);
        check("p6_success", success, 1);
        check("p6_steps", steps, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
